// File: rtl/udiv_recip_seq.sv
// udiv_recip_seq: sequential unsigned reciprocal, reciprocal = min(floor(2^FRAC_BITS / d), all-ones).
// Restoring shift-subtract divider producing one quotient bit per cycle, with a
// valid/ready handshake on both sides and a sideband tag carried with each operand.
// Optional macro UDIV_RECIP_ROUND_EN: round-to-nearest using one extra guard bit
// (ITER = FRAC_BITS+2) instead of truncation (ITER = FRAC_BITS+1).
module udiv_recip_seq #(
    parameter int unsigned IN_BITS   = 8,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned TAG_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_BITS-1:0]   number_in,
    input  logic [TAG_BITS-1:0]  tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAC_BITS-1:0] reciprocal,
    output logic                 saturated,
    output logic                 div_by_zero,
    output logic [TAG_BITS-1:0]  tag_out
);

`ifdef UDIV_RECIP_ROUND_EN
    localparam int unsigned ITER = FRAC_BITS + 2;
`else
    localparam int unsigned ITER = FRAC_BITS + 1;
`endif
    localparam int unsigned CNT_W = $clog2(ITER + 1);
    localparam int unsigned REM_W = IN_BITS + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IN_BITS-1:0]   divisor;
    logic [TAG_BITS-1:0]  tag_hold;
    logic [REM_W-1:0]     rem;
    // Quotient bits gathered so far; the final bit joins combinationally on the last step.
    logic [ITER-2:0]      quo;

    logic                 first_bit;
    logic                 last_step;
    logic [REM_W-1:0]     rem_shift;
    logic [REM_W:0]       diff;
    logic                 q_bit;
    logic [REM_W-1:0]     rem_next;
    logic [ITER-1:0]      quo_full;
    logic [FRAC_BITS-1:0] res_recip;
    logic                 res_sat;
    // Remainder stays below d, so its top bit is always zero once stored.
    logic                 unused_rem_msb;

    assign unused_rem_msb = rem[IN_BITS];
    assign in_ready       = (state == IDLE);

    // One restoring-division step: the dividend 2^(ITER-1) is a single 1 followed by zeros.
    always_comb begin
        first_bit = (cnt == '0);
        last_step = (cnt == CNT_W'(ITER - 1));
        rem_shift = {rem[IN_BITS-1:0], first_bit};
        diff      = {1'b0, rem_shift} - {2'b00, divisor};
        q_bit     = ~diff[REM_W];
        rem_next  = q_bit ? diff[REM_W-1:0] : rem_shift;
        quo_full  = {quo, q_bit};
    end

`ifdef UDIV_RECIP_ROUND_EN
    logic [FRAC_BITS+1:0] rounded;

    // Halve the doubled quotient and add the guard bit (ties round up), then saturate.
    always_comb begin
        rounded   = {1'b0, quo_full[ITER-1:1]} + {{(FRAC_BITS + 1){1'b0}}, quo_full[0]};
        res_sat   = |rounded[FRAC_BITS+1:FRAC_BITS];
        res_recip = res_sat ? '1 : rounded[FRAC_BITS-1:0];
    end
`else
    // Truncated quotient; only d == 1 sets the integer bit.
    always_comb begin
        res_sat   = quo_full[FRAC_BITS];
        res_recip = res_sat ? '1 : quo_full[FRAC_BITS-1:0];
    end
`endif

    // Control FSM, divider datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            divisor     <= '0;
            tag_hold    <= '0;
            rem         <= '0;
            quo         <= '0;
            out_valid   <= 1'b0;
            reciprocal  <= '0;
            saturated   <= 1'b0;
            div_by_zero <= 1'b0;
            tag_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        divisor  <= number_in;
                        tag_hold <= tag_in;
                        cnt      <= '0;
                        rem      <= '0;
                        quo      <= '0;
                        if (number_in == '0) begin
                            // Zero divisor skips the divider and reports immediately.
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            reciprocal  <= '1;
                            saturated   <= 1'b1;
                            div_by_zero <= 1'b1;
                            tag_out     <= tag_in;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= quo_full[ITER-2:0];
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        state       <= DONE;
                        cnt         <= '0;
                        out_valid   <= 1'b1;
                        reciprocal  <= res_recip;
                        saturated   <= res_sat;
                        div_by_zero <= 1'b0;
                        tag_out     <= tag_hold;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udiv_recip_seq.sv
// Self-checking bench for udiv_recip_seq (IN_BITS=8, FRAC_BITS=8, TAG_BITS=4).
// Define UDIV_RECIP_ROUND_EN for both bench and RTL to check the rounding build.
module tb_udiv_recip_seq;

    localparam int IN_BITS   = 8;
    localparam int FRAC_BITS = 8;
    localparam int TAG_BITS  = 4;
`ifdef UDIV_RECIP_ROUND_EN
    localparam int ITER = FRAC_BITS + 2;
    localparam int EXP_D6 = 8'h2B;
`else
    localparam int ITER = FRAC_BITS + 1;
    localparam int EXP_D6 = 8'h2A;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [IN_BITS-1:0]   number_in = '0;
    logic [TAG_BITS-1:0]  tag_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [FRAC_BITS-1:0] reciprocal;
    logic                 saturated;
    logic                 div_by_zero;
    logic [TAG_BITS-1:0]  tag_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    udiv_recip_seq #(
        .IN_BITS  (IN_BITS),
        .FRAC_BITS(FRAC_BITS),
        .TAG_BITS (TAG_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .number_in  (number_in),
        .tag_in     (tag_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .reciprocal (reciprocal),
        .saturated  (saturated),
        .div_by_zero(div_by_zero),
        .tag_out    (tag_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division of 2^FRAC_BITS by d, rounded or truncated.
    function automatic void model(input int d, output int r, output bit sat, output bit dbz);
        int q;
        int full;
        full = (1 << FRAC_BITS) - 1;
        if (d == 0) begin
            r = full; sat = 1'b1; dbz = 1'b1;
        end else begin
`ifdef UDIV_RECIP_ROUND_EN
            q = (2 << FRAC_BITS) / d;
            q = q / 2 + q % 2;
`else
            q = (1 << FRAC_BITS) / d;
`endif
            sat = (q > full);
            r   = sat ? full : q;
            dbz = 1'b0;
        end
    endfunction

    // Offer one operand and count edges (accepting edge = 1) until out_valid is seen.
    task automatic send(input logic [7:0] d, input logic [3:0] t, output int edges);
        int w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        number_in = d; tag_in = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 200) begin @(posedge clk); #1; edges++; end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++; if (reciprocal !== 8'h00) begin errors++; $display("FAIL reset reciprocal: got %h expected 00", reciprocal); end
        checks++; if ({saturated, div_by_zero} !== 2'b00) begin errors++; $display("FAIL reset flags: got %b%b expected 00", saturated, div_by_zero); end
        checks++; if (tag_out !== 4'h0) begin errors++; $display("FAIL reset tag_out: got %h expected 0", tag_out); end
    endtask

    task automatic test_directed();
        int dv[6]   = '{3, 6, 255, 1, 2, 0};
        int tv[6]   = '{4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        int rv[6]   = '{8'h55, EXP_D6, 8'h01, 8'hFF, 8'h80, 8'hFF};
        int sv[6]   = '{0, 0, 0, 1, 0, 1};
        int zv[6]   = '{0, 0, 0, 0, 0, 1};
        int lat;
        int exp_lat;
        for (int i = 0; i < 6; i++) begin
            send(dv[i][7:0], tv[i][3:0], lat);
            exp_lat = (dv[i] == 0) ? 1 : ITER + 1;
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL directed d=%0d latency: got %0d expected %0d", dv[i], lat, exp_lat); end
            checks++; if (reciprocal !== rv[i][7:0]) begin errors++; $display("FAIL directed d=%0d reciprocal: got %h expected %h", dv[i], reciprocal, rv[i][7:0]); end
            checks++; if (saturated !== sv[i][0]) begin errors++; $display("FAIL directed d=%0d saturated: got %b expected %b", dv[i], saturated, sv[i][0]); end
            checks++; if (div_by_zero !== zv[i][0]) begin errors++; $display("FAIL directed d=%0d div_by_zero: got %b expected %b", dv[i], div_by_zero, zv[i][0]); end
            checks++; if (tag_out !== tv[i][3:0]) begin errors++; $display("FAIL directed d=%0d tag_out: got %h expected %h", dv[i], tag_out, tv[i][3:0]); end
            pop();
        end
    endtask

    task automatic test_random();
        int d, t, lat, r;
        bit s, z;
        for (int i = 0; i < 24; i++) begin
            d = $urandom_range(0, 255);
            t = $urandom_range(0, 15);
            model(d, r, s, z);
            send(d[7:0], t[3:0], lat);
            checks++; if (lat !== ((d == 0) ? 1 : ITER + 1)) begin errors++; $display("FAIL random d=%0d latency: got %0d", d, lat); end
            checks++;
            if ({reciprocal, saturated, div_by_zero, tag_out} !== {r[7:0], s, z, t[3:0]}) begin
                errors++;
                $display("FAIL random d=%0d result: got r=%h s=%b z=%b t=%h expected r=%h s=%b z=%b t=%h",
                         d, reciprocal, saturated, div_by_zero, tag_out, r[7:0], s, z, t[3:0]);
            end
            pop();
        end
    endtask

    task automatic test_backpressure();
        int lat, r;
        bit s, z;
        model(7, r, s, z);
        send(8'd7, 4'h5, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            number_in = 8'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold cycle %0d handshake: got out_valid=%b in_ready=%b expected 1 0", i, out_valid, in_ready); end
            checks++;
            if ({reciprocal, saturated, div_by_zero, tag_out} !== {r[7:0], s, z, 4'h5}) begin
                errors++;
                $display("FAIL hold cycle %0d result: got r=%h s=%b z=%b t=%h expected r=%h s=%b z=%b t=5",
                         i, reciprocal, saturated, div_by_zero, tag_out, r[7:0], s, z);
            end
        end
        pop();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL after pop: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
        repeat (ITER + 3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ignored pulses produced result: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        int seen = 0;
        number_in = 8'd9; tag_in = 4'h6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid-calc reset: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
        for (int i = 0; i < ITER + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL aborted result presented: got %0d valid cycles expected 0", seen); end
        send(8'd4, 4'h7, lat);
        checks++; if (reciprocal !== 8'h40 || tag_out !== 4'h7) begin errors++; $display("FAIL post-reset d=4: got r=%h t=%h expected 40 7", reciprocal, tag_out); end
        checks++; if (lat !== ITER + 1) begin errors++; $display("FAIL post-reset latency: got %0d expected %0d", lat, ITER + 1); end
        pop();
    endtask

    task automatic test_back_to_back();
        int acc[5];
        int dv[5];
        int tv[5];
        int r, w;
        bit s, z;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dv[k] = $urandom_range(1, 255);
            tv[k] = k + 9;
            number_in = dv[k][7:0];
            tag_in    = tv[k][3:0];
            w = 0;
            while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
            acc[k] = cyc;
            @(posedge clk); #1;
            w = 0;
            while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
            model(dv[k], r, s, z);
            checks++; if (tag_out !== tv[k][3:0] || reciprocal !== r[7:0]) begin errors++; $display("FAIL b2b %0d: got t=%h r=%h expected t=%h r=%h", k, tag_out, reciprocal, tv[k][3:0], r[7:0]); end
            if (k > 0) begin
                checks++;
                if (acc[k] - acc[k-1] !== ITER + 2) begin errors++; $display("FAIL b2b spacing %0d: got %0d expected %0d", k, acc[k] - acc[k-1], ITER + 2); end
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
